// File: rtl/thor2022_reb_ctrl_if.sv
// Decode/execute/commit bundle for the REB allocate/commit controller.
// The master side (decode/execute) drives requests and completions; the
// slave side (the controller) returns slot offers, commit info and count.
interface thor2022_reb_ctrl_if #(
  parameter int RBITS = 3
);
  logic             alloc0_req;
  logic             alloc0_rfwr;
  logic [5:0]       alloc0_Rt;
  logic             alloc1_req;
  logic             alloc1_rfwr;
  logic [5:0]       alloc1_Rt;
  logic             done_v;
  logic [RBITS-1:0] done_id;
  logic             done_exc;
  logic             branchmiss;
  logic [RBITS-1:0] missid;
  logic [RBITS-1:0] dec0;
  logic [RBITS-1:0] dec1;
  logic [RBITS-1:0] head0;
  logic             commit0_v;
  logic [5:0]       commit0_id;
  logic             commit0_wr;
  logic [5:0]       commit0_tgt;
  logic             commit1_v;
  logic             commit1_wr;
  logic [5:0]       commit1_tgt;
  logic             exc_v;
  logic [RBITS-1:0] count;

  modport master (
    output alloc0_req, alloc0_rfwr, alloc0_Rt,
    output alloc1_req, alloc1_rfwr, alloc1_Rt,
    output done_v, done_id, done_exc, branchmiss, missid,
    input  dec0, dec1, head0,
    input  commit0_v, commit0_id, commit0_wr, commit0_tgt,
    input  commit1_v, commit1_wr, commit1_tgt,
    input  exc_v, count
  );

  modport slave (
    input  alloc0_req, alloc0_rfwr, alloc0_Rt,
    input  alloc1_req, alloc1_rfwr, alloc1_Rt,
    input  done_v, done_id, done_exc, branchmiss, missid,
    output dec0, dec1, head0,
    output commit0_v, commit0_id, commit0_wr, commit0_tgt,
    output commit1_v, commit1_wr, commit1_tgt,
    output exc_v, count
  );
endinterface

// File: rtl/thor2022_reb_ctrl.sv
// Reorder-buffer allocate/commit controller.
// Hands out up to two ring slots per cycle, tracks FREE->DECODED->DONE per
// entry, retires in order from the head, rolls the tail back on a branch
// mispredict and flushes everything when a retiring entry carries an
// exception. The ring holds REB_ENTRIES-1 usable slots; the last index is
// the "no entry" code and is never stored.
// Optional feature macro: THOR_DUAL_COMMIT_EN (second retire per cycle).
module thor2022_reb_ctrl #(
  parameter int REB_ENTRIES = 8,
  parameter int RBITS       = $clog2(REB_ENTRIES)
) (
  input logic                clk,
  input logic                rst,
  thor2022_reb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_DECODED = 2'd1,
    ST_DONE    = 2'd2
  } ent_st_e;

  localparam logic [RBITS-1:0] NONE_IDX = RBITS'(REB_ENTRIES - 1);
  localparam logic [RBITS-1:0] LAST_IDX = RBITS'(REB_ENTRIES - 2);
  localparam logic [RBITS:0]   SLOTS    = (RBITS+1)'(REB_ENTRIES - 1);
  localparam logic [RBITS:0]   ONE_W    = (RBITS+1)'(1);

  // Next index in ring order; the reserved index is skipped.
  function automatic logic [RBITS-1:0] ring_inc(input logic [RBITS-1:0] idx);
    logic [RBITS-1:0] r;
    if (idx == LAST_IDX) r = {RBITS{1'b0}};
    else                 r = idx + RBITS'(1);
    return r;
  endfunction

  // Distance from from_idx forward to to_idx, modulo the usable slot count.
  function automatic logic [RBITS-1:0] ring_dist(input logic [RBITS-1:0] from_idx,
                                                 input logic [RBITS-1:0] to_idx);
    logic [RBITS:0] d;
    if (to_idx >= from_idx) d = {1'b0, to_idx} - {1'b0, from_idx};
    else                    d = {1'b0, to_idx} + SLOTS - {1'b0, from_idx};
    return d[RBITS-1:0];
  endfunction

  ent_st_e          st_q   [REB_ENTRIES];
  ent_st_e          st_d   [REB_ENTRIES];
  logic             rfwr_q [REB_ENTRIES];
  logic             rfwr_d [REB_ENTRIES];
  logic [5:0]       rt_q   [REB_ENTRIES];
  logic [5:0]       rt_d   [REB_ENTRIES];
  logic             exc_q  [REB_ENTRIES];
  logic             exc_d  [REB_ENTRIES];
  logic [RBITS-1:0] head_q, head_d;
  logic [RBITS-1:0] tail_q, tail_d;
  logic [RBITS-1:0] count_q, count_d;

  logic             commit0_v_s;
  logic             commit1_v_s;
  logic             exc_flush_s;
  logic             alloc0_ok_s;
  logic             alloc1_ok_s;
  logic [RBITS:0]   n_alloc_s;
  logic [RBITS:0]   n_commit_s;
  logic [RBITS-1:0] miss_dist_s;

  // ---------------- output decode of registered state ----------------
  assign commit0_v_s     = (st_q[head_q] == ST_DONE);
  assign exc_flush_s     = commit0_v_s & exc_q[head_q];

  assign bus.dec0        = (count_q <= RBITS'(REB_ENTRIES - 2)) ? tail_q : NONE_IDX;
  assign bus.dec1        = (count_q <= RBITS'(REB_ENTRIES - 3)) ? ring_inc(tail_q) : NONE_IDX;
  assign bus.head0       = head_q;
  assign bus.count       = count_q;
  assign bus.commit0_v   = commit0_v_s;
  assign bus.commit0_id  = commit0_v_s ? 6'(head_q) : 6'd0;
  assign bus.commit0_wr  = commit0_v_s & rfwr_q[head_q] & ~exc_q[head_q];
  assign bus.commit0_tgt = commit0_v_s ? rt_q[head_q] : 6'd0;
  assign bus.exc_v       = exc_flush_s;

`ifdef THOR_DUAL_COMMIT_EN
  logic [RBITS-1:0] head1_s;
  assign head1_s         = ring_inc(head_q);
  assign commit1_v_s     = commit0_v_s & ~exc_q[head_q] &
                           (st_q[head1_s] == ST_DONE) & ~exc_q[head1_s];
  assign bus.commit1_v   = commit1_v_s;
  assign bus.commit1_wr  = commit1_v_s & rfwr_q[head1_s];
  assign bus.commit1_tgt = commit1_v_s ? rt_q[head1_s] : 6'd0;
`else
  assign commit1_v_s     = 1'b0;
  assign bus.commit1_v   = 1'b0;
  assign bus.commit1_wr  = 1'b0;
  assign bus.commit1_tgt = 6'd0;
`endif

  // Grants: flushes of either kind drop this cycle's allocations.
  assign alloc0_ok_s = bus.alloc0_req & (bus.dec0 != NONE_IDX) &
                       ~exc_flush_s & ~bus.branchmiss;
  assign alloc1_ok_s = alloc0_ok_s & bus.alloc1_req & (bus.dec1 != NONE_IDX);
  assign n_alloc_s   = {{RBITS{1'b0}}, alloc0_ok_s} + {{RBITS{1'b0}}, alloc1_ok_s};
  assign n_commit_s  = {{RBITS{1'b0}}, commit0_v_s} + {{RBITS{1'b0}}, commit1_v_s};
  assign miss_dist_s = ring_dist(head_q, bus.missid);

  // Next-state for entries and ring pointers: exception > branchmiss > allocation.
  always_comb begin
    for (int i = 0; i < REB_ENTRIES; i++) begin
      st_d[i]   = st_q[i];
      rfwr_d[i] = rfwr_q[i];
      rt_d[i]   = rt_q[i];
      exc_d[i]  = exc_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (exc_flush_s) begin
      for (int i = 0; i < REB_ENTRIES; i++) begin
        st_d[i] = ST_FREE;
      end
      head_d  = ring_inc(head_q);
      tail_d  = ring_inc(head_q);
      count_d = {RBITS{1'b0}};
    end else begin
      // Completion; an entry being flushed by a same-edge mispredict stays put.
      if (bus.done_v && (bus.done_id != NONE_IDX) && (st_q[bus.done_id] == ST_DECODED) &&
          !(bus.branchmiss && (ring_dist(head_q, bus.done_id) > miss_dist_s))) begin
        st_d[bus.done_id]  = ST_DONE;
        exc_d[bus.done_id] = bus.done_exc;
      end else begin
        st_d[bus.done_id]  = st_d[bus.done_id];
      end

      // In-order retire from the head.
      if (commit1_v_s) begin
        st_d[head_q]           = ST_FREE;
        st_d[ring_inc(head_q)] = ST_FREE;
        head_d                 = ring_inc(ring_inc(head_q));
      end else if (commit0_v_s) begin
        st_d[head_q] = ST_FREE;
        head_d       = ring_inc(head_q);
      end else begin
        head_d = head_q;
      end

      if (bus.branchmiss) begin
        // Everything younger than the mispredicted branch is discarded.
        for (int i = 0; i < REB_ENTRIES - 1; i++) begin
          if (ring_dist(head_q, RBITS'(i)) > miss_dist_s) st_d[i] = ST_FREE;
          else                                            st_d[i] = st_d[i];
        end
        tail_d  = ring_inc(bus.missid);
        count_d = RBITS'({1'b0, miss_dist_s} + ONE_W - n_commit_s);
      end else begin
        if (alloc0_ok_s) begin
          st_d[tail_q]   = ST_DECODED;
          rfwr_d[tail_q] = bus.alloc0_rfwr;
          rt_d[tail_q]   = bus.alloc0_Rt;
          exc_d[tail_q]  = 1'b0;
        end else begin
          st_d[tail_q]   = st_d[tail_q];
        end
        if (alloc1_ok_s) begin
          st_d[ring_inc(tail_q)]   = ST_DECODED;
          rfwr_d[ring_inc(tail_q)] = bus.alloc1_rfwr;
          rt_d[ring_inc(tail_q)]   = bus.alloc1_Rt;
          exc_d[ring_inc(tail_q)]  = 1'b0;
          tail_d                   = ring_inc(ring_inc(tail_q));
        end else if (alloc0_ok_s) begin
          tail_d = ring_inc(tail_q);
        end else begin
          tail_d = tail_q;
        end
        count_d = RBITS'({1'b0, count_q} + n_alloc_s - n_commit_s);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REB_ENTRIES; i++) begin
        st_q[i]   <= ST_FREE;
        rfwr_q[i] <= 1'b0;
        rt_q[i]   <= 6'd0;
        exc_q[i]  <= 1'b0;
      end
      head_q  <= {RBITS{1'b0}};
      tail_q  <= {RBITS{1'b0}};
      count_q <= {RBITS{1'b0}};
    end else begin
      for (int i = 0; i < REB_ENTRIES; i++) begin
        st_q[i]   <= st_d[i];
        rfwr_q[i] <= rfwr_d[i];
        rt_q[i]   <= rt_d[i];
        exc_q[i]  <= exc_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
